// File: rtl/multiplier_pkg.sv
// Shared constants and state encoding for the Montgomery multiplier family.
// Holds the default operand width and the precompute FSM encoding.
package multiplier_pkg;

    localparam int MONT_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BITLEN = 3'd1,
        ST_INVERT = 3'd2,
        ST_R2SQ   = 3'd3,
        ST_DONE   = 3'd4
    } precomp_state_t;

endpackage

// File: rtl/msb_index.sv
// Combinational priority encoder: returns MSB position + 1, or 0 for a zero input.
// The result is the bit length of the operand.
module msb_index #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_bitlen
);

    always_comb begin
        o_bitlen = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (i_value[k]) o_bitlen = WIDTH'(k + 1);
        end
    end

endmodule

// File: rtl/montgomery_precompute.sv
// Derives bit length, -m^-1 mod 2^bl and (optionally) R^2 mod m for the Montgomery reducer.
// Optional R^2 stage is built only when MONT_PRECOMP_R2_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start_i, m_i latched on accept
// BITLEN | bit length of m, reject even/zero modulus
// INVERT | bit-serial Hensel lifting of m^-1, one bit per cycle
// R2SQ   | 2*bl modular doublings to form R^2 mod m
// DONE   | one-cycle valid_o pulse, results held afterwards
module montgomery_precompute
    import multiplier_pkg::*;
#(
    parameter int WIDTH = MONT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] m_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic             error_o,
    output logic [WIDTH-1:0] m_bl_o,
    output logic [WIDTH-1:0] minv_o,
    output logic [WIDTH-1:0] r2_o
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_I = IW'(WIDTH - 1);

    precomp_state_t r_state, w_next;

    logic [WIDTH-1:0] r_m, r_bl, r_inv, r_t, r_m_bl, r_minv;
    logic [IW-1:0]    r_i;
    logic             r_error;

    logic [WIDTH-1:0] w_bl, w_inv_next, w_t_next, w_mask, w_minv;
    logic             w_tbit, w_last_step;

    msb_index #(.WIDTH(WIDTH)) u_msb_index (
        .i_value  (r_m),
        .o_bitlen (w_bl)
    );

    assign w_last_step = (r_i == LAST_I);
    assign w_tbit      = r_t[r_i];
    assign w_inv_next  = w_tbit ? (r_inv | (WIDTH'(1) << r_i)) : r_inv;
    assign w_t_next    = w_tbit ? (r_t + (r_m << r_i)) : r_t;
    // Full-width mask is selected explicitly so 1<<WIDTH is never formed.
    assign w_mask      = (r_bl == WIDTH'(WIDTH)) ? '1 : ((WIDTH'(1) << r_bl) - WIDTH'(1));
    assign w_minv      = (WIDTH'(0) - w_inv_next) & w_mask;

`ifdef MONT_PRECOMP_R2_EN
    localparam int CW = $clog2(2 * WIDTH + 1);

    logic [WIDTH:0]   r_x, w_x_dbl, w_x_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_r2;

    assign w_x_dbl  = {r_x[WIDTH-1:0], 1'b0};
    assign w_x_next = (w_x_dbl >= {1'b0, r_m}) ? (w_x_dbl - {1'b0, r_m}) : w_x_dbl;
    assign r2_o     = r_r2;
`else
    assign r2_o     = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start_i) w_next = ST_BITLEN;
            ST_BITLEN: w_next = r_m[0] ? ST_INVERT : ST_DONE;
            ST_INVERT: begin
                if (w_last_step) begin
`ifdef MONT_PRECOMP_R2_EN
                    w_next = ST_R2SQ;
`else
                    w_next = ST_DONE;
`endif
                end
            end
`ifdef MONT_PRECOMP_R2_EN
            ST_R2SQ:   if (r_cnt == CW'(1)) w_next = ST_DONE;
`endif
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_m     <= '0;
            r_bl    <= '0;
            r_inv   <= '0;
            r_t     <= '0;
            r_i     <= '0;
            r_error <= 1'b0;
            r_m_bl  <= '0;
            r_minv  <= '0;
`ifdef MONT_PRECOMP_R2_EN
            r_x     <= '0;
            r_cnt   <= '0;
            r_r2    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (start_i) r_m <= m_i;
                ST_BITLEN: begin
                    r_bl <= w_bl;
                    if (!r_m[0]) begin
                        r_error <= 1'b1;
                        r_m_bl  <= '0;
                        r_minv  <= '0;
`ifdef MONT_PRECOMP_R2_EN
                        r_r2    <= '0;
`endif
                    end else begin
                        r_inv <= WIDTH'(1);
                        r_t   <= r_m;
                        r_i   <= IW'(1);
                    end
                end
                ST_INVERT: begin
                    r_inv <= w_inv_next;
                    r_t   <= w_t_next;
                    r_i   <= r_i + IW'(1);
                    if (w_last_step) begin
                        r_m_bl  <= r_bl;
                        r_minv  <= w_minv;
                        r_error <= 1'b0;
`ifdef MONT_PRECOMP_R2_EN
                        r_x   <= (r_m == WIDTH'(1)) ? '0 : (WIDTH + 1)'(1);
                        r_cnt <= {r_bl[CW-2:0], 1'b0};
`endif
                    end
                end
`ifdef MONT_PRECOMP_R2_EN
                ST_R2SQ: begin
                    r_x   <= w_x_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_r2 <= w_x_next[WIDTH-1:0];
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy_o  = (r_state != ST_IDLE);
    assign valid_o = (r_state == ST_DONE);
    assign error_o = r_error;
    assign m_bl_o  = r_m_bl;
    assign minv_o  = r_minv;

endmodule
